// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
//
// Front end for the four active-low lane buttons of the game stage. Each raw
// pad is synchronized to clk_i, then debounced by an independent per-lane
// state machine. The block produces clean active-low levels, one-cycle
// press/release pulses and a saturating count of accepted presses.
//
// Ports
//   clk_i          system clock, all flops on the rising edge
//   reset_i        asynchronous reset, active low
//   b_raw_i[3:0]   raw button pads, active low, asynchronous to clk_i
//   b_clean_o[3:0] debounced level, active low (bit 0 drives game-stage b1)
//   press_o[3:0]   one-cycle pulse when a press is accepted
//   release_o[3:0] one-cycle pulse when a release is accepted
//   press_total_o  accepted presses over all lanes, saturates at 255
//   dbg_state_o    per-lane FSM state, lane i in bits [2*i+1:2*i]
//                  (0 IDLE, 1 PRESS_WAIT, 2 PRESSED, 3 RELEASE_WAIT)
//
// There is no combinational path from b_raw_i to any output.
// -----------------------------------------------------------------------------
module key_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [3:0] b_raw_i,
    output logic [3:0] b_clean_o,
    output logic [3:0] press_o,
    output logic [3:0] release_o,
    output logic [7:0] press_total_o,
    output logic [7:0] dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } lane_state_e;

    // Terminal count of a WAIT state; DEBOUNCE_CYCLES may equal 2^CNT_W,
    // so only DEBOUNCE_CYCLES-1 has to fit in the counter.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]       s1_q, s2_q;
    lane_state_e      state_q [4];
    lane_state_e      state_d [4];
    logic [CNT_W-1:0] cnt_q   [4];
    logic [CNT_W-1:0] cnt_d   [4];
    logic [3:0]       clean_q, clean_d;
    logic [3:0]       press_q, press_d;
    logic [3:0]       release_q, release_d;
    logic [7:0]       total_q, total_d;
    logic [2:0]       press_cnt;
    logic [8:0]       total_sum;

    // Two-flop synchronizer. Resetting to 1 (released) keeps a button held
    // through reset from looking like a fresh edge at deassertion.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            s1_q <= 4'hF;
            s2_q <= 4'hF;
        end else begin
            s1_q <= b_raw_i;
            s2_q <= s1_q;
        end
    end

    // Per-lane debounce FSMs and the output registers they drive.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clean_d   = clean_q;
        press_d   = 4'b0000;
        release_d = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            case (state_q[i])
                IDLE: begin
                    if (!s2_q[i]) begin
                        state_d[i] = PRESS_WAIT;
                        cnt_d[i]   = '0;
                    end
                end
                PRESS_WAIT: begin
                    if (s2_q[i]) begin
                        // Bounce: throw the partial count away.
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i] = PRESSED;
                        clean_d[i] = 1'b0;
                        press_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                PRESSED: begin
                    if (s2_q[i]) begin
                        state_d[i] = RELEASE_WAIT;
                        cnt_d[i]   = '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (!s2_q[i]) begin
                        state_d[i] = PRESSED;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_LAST) begin
                        state_d[i]   = IDLE;
                        clean_d[i]   = 1'b1;
                        release_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Press counter adds the number of presses accepted on this edge, so
    // simultaneous presses land in a single update; clamps instead of wrapping.
    always_comb begin
        press_cnt = 3'd0;
        for (int i = 0; i < 4; i++) begin
            press_cnt = press_cnt + {2'b00, press_d[i]};
        end
        total_sum = {1'b0, total_q} + {6'b000000, press_cnt};
        total_d   = total_sum[8] ? 8'hFF : total_sum[7:0];
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            clean_q   <= 4'hF;
            press_q   <= 4'b0000;
            release_q <= 4'b0000;
            total_q   <= 8'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            clean_q   <= clean_d;
            press_q   <= press_d;
            release_q <= release_d;
            total_q   <= total_d;
        end
    end

    always_comb begin
        dbg_state_o = 8'd0;
        for (int i = 0; i < 4; i++) begin
            dbg_state_o[2*i +: 2] = state_q[i];
        end
    end

    assign b_clean_o     = clean_q;
    assign press_o       = press_q;
    assign release_o     = release_q;
    assign press_total_o = total_q;

endmodule

// File: tb/tb_key_conditioner.sv
// -----------------------------------------------------------------------------
// tb_key_conditioner
//
// Bench for key_conditioner with DEBOUNCE_CYCLES=4. A table of per-cycle
// vectors covers the idle, single-lane and all-lane press/release cases;
// bounce, saturation and mid-count reset are written out by hand.
// Inputs change 1 ns after a rising edge; outputs are read at the same point,
// so vector j's input is sampled on the edge that precedes its checks.
// -----------------------------------------------------------------------------
module tb_key_conditioner;

    localparam int unsigned D = 4;

    logic       clk;
    logic       reset_n;
    logic [3:0] b_raw;
    logic [3:0] b_clean;
    logic [3:0] press;
    logic [3:0] rel;
    logic [7:0] press_total;
    logic [7:0] dbg_state;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [3:0] raw;
        logic [3:0] clean;
        logic [3:0] prs;
        logic [3:0] rls;
        logic [7:0] total;
    } vec_t;

    vec_t vecs[$];

    key_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_n),
        .b_raw_i      (b_raw),
        .b_clean_o    (b_clean),
        .press_o      (press),
        .release_o    (rel),
        .press_total_o(press_total),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] c, input logic [3:0] p,
                              input logic [3:0] r, input logic [7:0] t);
        check({tag, ".clean"}, {28'd0, b_clean}, {28'd0, c});
        check({tag, ".press"}, {28'd0, press}, {28'd0, p});
        check({tag, ".release"}, {28'd0, rel}, {28'd0, r});
        check({tag, ".total"}, {24'd0, press_total}, {24'd0, t});
    endtask

    function automatic void add(input logic [3:0] raw, input logic [3:0] c, input logic [3:0] p,
                                input logic [3:0] r, input logic [7:0] t, input int n);
        vec_t v;
        v.raw = raw; v.clean = c; v.prs = p; v.rls = r; v.total = t;
        for (int k = 0; k < n; k++) vecs.push_back(v);
    endfunction

    // ---------------- test ----------------
    initial begin
        int exp_total;
        int base;

        // Idle: released for 20 cycles.
        add(4'hF, 4'hF, 4'h0, 4'h0, 8'd0, 20);
        // Lane 2 press held 10 cycles: accepted 6 edges after the first low sample.
        add(4'hB, 4'hF, 4'h0, 4'h0, 8'd0, 6);
        add(4'hB, 4'hB, 4'h4, 4'h0, 8'd1, 1);
        add(4'hB, 4'hB, 4'h0, 4'h0, 8'd1, 3);
        // Lane 2 release: symmetric 6-edge latency.
        add(4'hF, 4'hB, 4'h0, 4'h0, 8'd1, 6);
        add(4'hF, 4'hF, 4'h0, 4'h4, 8'd1, 1);
        add(4'hF, 4'hF, 4'h0, 4'h0, 8'd1, 3);
        // All four lanes pressed on one edge: counter jumps by 4 at once.
        add(4'h0, 4'hF, 4'h0, 4'h0, 8'd1, 6);
        add(4'h0, 4'h0, 4'hF, 4'h0, 8'd5, 1);
        add(4'h0, 4'h0, 4'h0, 4'h0, 8'd5, 3);
        add(4'hF, 4'h0, 4'h0, 4'h0, 8'd5, 6);
        add(4'hF, 4'hF, 4'h0, 4'hF, 8'd5, 1);
        add(4'hF, 4'hF, 4'h0, 4'h0, 8'd5, 3);

        // Reset: make a real falling edge on reset_n before the first clock.
        reset_n = 1'b1;
        b_raw   = 4'hF;
        #2 reset_n = 1'b0;
        #1;
        check_outs("reset", 4'hF, 4'h0, 4'h0, 8'd0);
        check("reset.state", {24'd0, dbg_state}, 32'd0);
        step();
        step();
        reset_n = 1'b1;

        for (int j = 0; j < vecs.size(); j++) begin
            b_raw = vecs[j].raw;
            step();
            check_outs($sformatf("vec[%0d]", j), vecs[j].clean, vecs[j].prs, vecs[j].rls, vecs[j].total);
        end

        // Bounce on lane 0: 0,0,1,1,0,0,1,1 then hold 0. Short lows never qualify.
        base = 5;
        for (int seg = 0; seg < 4; seg++) begin
            for (int k = 0; k < 2; k++) begin
                b_raw = (seg % 2 == 0) ? 4'hE : 4'hF;
                step();
                check_outs($sformatf("bounce.toggle[%0d]", seg * 2 + k), 4'hF, 4'h0, 4'h0, 8'(base));
            end
        end
        b_raw = 4'hE;
        for (int k = 0; k < 9; k++) begin
            step();
            check_outs($sformatf("bounce.hold[%0d]", k), (k >= 6) ? 4'hE : 4'hF,
                       (k == 6) ? 4'h1 : 4'h0, 4'h0, 8'((k >= 6) ? base + 1 : base));
        end
        b_raw = 4'hF;
        for (int k = 0; k < 8; k++) begin
            step();
            check_outs($sformatf("bounce.rel[%0d]", k), (k >= 6) ? 4'hF : 4'hE,
                       4'h0, (k == 6) ? 4'h1 : 4'h0, 8'(base + 1));
        end

        // Saturation: 64 four-lane presses from 6 pass through 254 and clamp.
        exp_total = base + 1;
        for (int it = 0; it < 64; it++) begin
            b_raw = 4'h0;
            for (int k = 0; k < 7; k++) begin
                step();
                if (k == 6) begin
                    exp_total = (exp_total + 4 > 255) ? 255 : exp_total + 4;
                    check($sformatf("sat[%0d].press", it), {28'd0, press}, 32'hF);
                    check($sformatf("sat[%0d].total", it), {24'd0, press_total}, exp_total);
                end
            end
            b_raw = 4'hF;
            for (int k = 0; k < 7; k++) step();
        end
        check("sat.final", {24'd0, press_total}, 32'd255);
        b_raw = 4'h0;
        for (int k = 0; k < 7; k++) step();
        check("sat.extra.press", {28'd0, press}, 32'hF);
        check("sat.extra.total", {24'd0, press_total}, 32'd255);
        b_raw = 4'hF;
        for (int k = 0; k < 8; k++) step();

        // Mid-count reset on lane 1: two edges into PRESS_WAIT.
        b_raw = 4'hD;
        step();                      // edge m: first low sample
        step();                      // m+1
        step();                      // m+2: PRESS_WAIT entered
        check("midrst.state", {30'd0, dbg_state[3:2]}, 32'd1);
        step();                      // m+3
        step();                      // m+4
        reset_n = 1'b0;
        #1;
        check_outs("midrst.assert", 4'hF, 4'h0, 4'h0, 8'd0);
        check("midrst.assert.state", {24'd0, dbg_state}, 32'd0);
        step();
        step();
        check_outs("midrst.held", 4'hF, 4'h0, 4'h0, 8'd0);
        reset_n = 1'b1;
        for (int k = 0; k < 9; k++) begin
            step();                  // k==0 is the first clocked sample after reset
            check_outs($sformatf("midrst.after[%0d]", k), (k >= 6) ? 4'hD : 4'hF,
                       (k == 6) ? 4'h2 : 4'h0, 4'h0, 8'((k >= 6) ? 1 : 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
# key_conditioner

Front-end conditioner for the four active-low lane buttons that drive the game stage. It synchronizes each raw pad input to `clk` and debounces it with a per-lane state machine. It then produces clean active-low levels, one-cycle press and release pulses, and a saturating total-press counter. The `b_clean` bus connects directly to the game stage's `b1`..`b4` inputs (bit 0 to `b1`).

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: stable-input cycles required to accept a change (20 ms at 50 MHz). Legal range is 2 to 2^CNT_W.
- `CNT_W`, default 20: width of each lane's debounce counter.

Ports:
- `clk`  in  1  system clock; every flop is clocked on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `b_raw`  in  4  raw button pads, active-low (0 = pressed), asynchronous to `clk`.
- `b_clean`  out  4  debounced button level, active-low, registered.
- `press`  out  4  one-cycle high pulse per lane when a press is accepted, registered.
- `release`  out  4  one-cycle high pulse per lane when a release is accepted, registered.
- `press_total`  out  8  count of accepted presses across all lanes, saturating, registered.

## Operation
- Synchronizer: each lane has 2 flops, `s1` then `s2`. Both reset to 1 (released). Only `s2` is used downstream.
- Each lane has an independent 4-state FSM with a `CNT_W`-bit counter `cnt`:
  - IDLE (released). If `s2`==0, go to PRESS_WAIT with `cnt`<=0. Otherwise stay.
  - PRESS_WAIT. If `s2`==1 (bounce), go to IDLE with `cnt`<=0. Else if `cnt`==DEBOUNCE_CYCLES-1, go to PRESSED. Else `cnt`<=`cnt`+1.
  - PRESSED. If `s2`==1, go to RELEASE_WAIT with `cnt`<=0. Otherwise stay.
  - RELEASE_WAIT. If `s2`==0 (bounce), go to PRESSED with `cnt`<=0. Else if `cnt`==DEBOUNCE_CYCLES-1, go to IDLE. Else `cnt`<=`cnt`+1.
- Outputs on FSM transitions:
  - PRESS_WAIT to PRESSED, same edge: `b_clean[i]`<=0 and `press[i]`<=1.
  - RELEASE_WAIT to IDLE, same edge: `b_clean[i]`<=1 and `release[i]`<=1.
  - `press` and `release` return to 0 on the next edge unless the lane re-qualifies, which cannot happen within DEBOUNCE_CYCLES.
- A bounce during a WAIT state discards the partial count. `b_clean` does not change and no pulse is emitted.
- `press_total` update:
  - Each edge, `press_total` <= min(255, `press_total` + popcount(`press` next value)).
  - Simultaneous presses on several lanes in one cycle add 2, 3 or 4 in that single edge.
  - At 255 the counter holds. Near the top it clamps; for example 254 plus 4 gives 255. It never wraps.
- Lanes are fully independent. Activity on one lane never alters another lane's state, counter or outputs.

## Timing
- Reset values while `reset`==0, applied asynchronously at assertion:
  - `b_clean`=4'hF; `press`=0; `release`=0; `press_total`=0.
  - All FSMs in IDLE; all `cnt`=0; `s1`=`s2`=4'hF.
- Release from reset: because the synchronizers reset to 1, no spurious press is produced after deassertion. A button held through reset is accepted DEBOUNCE_CYCLES+2 edges after the first clocked sample.
- Press latency (D = DEBOUNCE_CYCLES):
  - `b_raw[i]` is first sampled low at edge m and held low.
  - `s2` goes low after edge m+1, and PRESS_WAIT is entered at edge m+2.
  - `b_clean[i]` falls and `press[i]` rises after edge m+D+2. `press[i]` is high for exactly one cycle.
- Release latency is symmetric: D+2 edges from the first low-to-high sample to the `release` pulse.
- Reset asserted mid-count or mid-pulse: all state clears immediately. No pulse completes, and no pulse is emitted on deassertion.
- Combinational path from `b_raw` to outputs: none.

## Test plan
All scenarios run with DEBOUNCE_CYCLES=4.
- Reset, then `b_raw`=4'hF held for 20 cycles: `b_clean`=4'hF, `press`=0, `release`=0 and `press_total`=0 throughout.
- Clean press on lane 2: `b_raw[2]` driven 0 before edge m. Required response:
  - `b_clean[2]`=0 and `press`=4'b0100 for exactly one cycle after edge m+6.
  - `press_total`=1 thereafter.
  - Returning `b_raw[2]` to 1 gives `release`=4'b0100 one cycle, 6 edges later.
- Bounce: `b_raw[0]` toggles 0,1,0,1 every 2 cycles, then holds 0.
  - No `press` during the toggling.
  - One `press[0]` pulse 6 edges after the final falling sample.
  - `press_total` increments by exactly 1.
- Simultaneous press: `b_raw` goes 4'hF to 4'h0 on one edge. Required response:
  - `press`=4'hF for one cycle.
  - `press_total` goes 0 to 4 in a single edge.
  - `b_clean`=4'h0.
- Saturation: 64 simultaneous four-lane press/release cycles (256 accepted presses). `press_total` reads 255 and stays 255 on the next press.
- Mid-count reset: assert `reset` 2 edges into PRESS_WAIT on lane 1 while `b_raw[1]` stays 0.
  - All outputs return to reset values immediately.
  - After deassertion, `press[1]` fires 6 edges after the first clocked sample, never earlier.
